// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage: PC update, one-in-flight SRAM fetch, hold for ID
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_allowin,
  input  logic        in_br_taken,
  input  logic [31:0] in_br_target,
  output logic        inst_sram_req,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata,
  output logic        out_valid,
  input  logic        out_allowin,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_adef
);

  typedef enum logic [2:0] {
    S_RST,
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] inst_buf;
  logic        adef;
  logic        token;

  always_comb begin
    state_nx = state;
    next_pc  = in_br_taken ? in_br_target : pc + 32'd4;
    token    = (state == S_IDLE) && in_valid;
    case (state)
      S_RST:  state_nx = S_REQ;
      S_IDLE: begin
        // A misaligned target never reaches the SRAM; it goes straight to ID as an exception.
        if (in_valid) state_nx = (next_pc[1:0] == 2'b00) ? S_REQ : S_HOLD;
      end
      S_REQ:  if (inst_sram_addr_ok) state_nx = S_WAIT;
      S_WAIT: if (inst_sram_data_ok) state_nx = S_HOLD;
      S_HOLD: if (out_allowin) state_nx = S_IDLE;
      default: state_nx = S_RST;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RST;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      adef     <= 1'b0;
      inst_buf <= 32'd0;
    end else begin
      if (token) begin
        pc   <= next_pc;
        adef <= (next_pc[1:0] != 2'b00);
      end
      if (state == S_WAIT && inst_sram_data_ok) inst_buf <= inst_sram_rdata;
      if (state == S_HOLD && out_allowin) adef <= 1'b0;
    end
  end

  assign in_allowin     = (state == S_IDLE);
  assign inst_sram_req  = (state == S_REQ);
  assign inst_sram_addr = pc;
  assign out_valid      = (state == S_HOLD);
  assign out_pc         = pc;
  assign out_adef       = adef;
  assign out_inst       = (state == S_HOLD && !adef) ? inst_buf : 32'd0;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed and randomized checks of if_stage against a PC/transaction model
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h1c00_0000;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_allowin;
  logic        in_br_taken;
  logic [31:0] in_br_target;
  logic        inst_sram_req;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        out_valid;
  logic        out_allowin;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_adef;

  int          n_total;
  int          n_pass;
  logic [31:0] ref_pc;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .reset            (reset),
    .in_valid         (in_valid),
    .in_allowin       (in_allowin),
    .in_br_taken      (in_br_taken),
    .in_br_target     (in_br_target),
    .inst_sram_req    (inst_sram_req),
    .inst_sram_addr   (inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok),
    .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata  (inst_sram_rdata),
    .out_valid        (out_valid),
    .out_allowin      (out_allowin),
    .out_pc           (out_pc),
    .out_inst         (out_inst),
    .out_adef         (out_adef)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Ignored inputs get random values so a design that wrongly samples them shows it.
  task automatic noise(input bit addr_ok_on, input bit data_ok_on);
    in_valid          = 1'($urandom_range(1));
    in_br_taken       = 1'($urandom_range(1));
    in_br_target      = $urandom;
    inst_sram_rdata   = $urandom;
    inst_sram_addr_ok = addr_ok_on ? 1'($urandom_range(1)) : 1'b0;
    inst_sram_data_ok = data_ok_on ? 1'($urandom_range(1)) : 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk1({tag, "_req"}, inst_sram_req, 1'b0);
    chk1({tag, "_allowin"}, in_allowin, 1'b0);
    chk1({tag, "_valid"}, out_valid, 1'b0);
    chk1({tag, "_adef"}, out_adef, 1'b0);
    chk32({tag, "_pc"}, out_pc, RESET_PC);
    chk32({tag, "_addr"}, inst_sram_addr, RESET_PC);
    chk32({tag, "_inst"}, out_inst, 32'd0);
  endtask

  // Entered at the negedge of the first REQ cycle; leaves at the first HOLD cycle.
  task automatic run_fetch(input int aw, input int dw, input logic [31:0] rdata);
    for (int i = 0; i <= aw; i++) begin
      chk1("req_high", inst_sram_req, 1'b1);
      chk32("req_addr", inst_sram_addr, ref_pc);
      chk1("req_no_valid", out_valid, 1'b0);
      chk1("req_allowin", in_allowin, 1'b0);
      noise(1'b0, 1'b1);
      if (i == aw) begin
        inst_sram_addr_ok = 1'b1;
        inst_sram_data_ok = 1'b0;
      end
      tick();
    end
    for (int i = 0; i <= dw; i++) begin
      chk1("wait_req_low", inst_sram_req, 1'b0);
      chk1("wait_no_valid", out_valid, 1'b0);
      chk1("wait_allowin", in_allowin, 1'b0);
      noise(1'b1, 1'b0);
      if (i == dw) begin
        inst_sram_data_ok = 1'b1;
        inst_sram_rdata   = rdata;
      end
      tick();
    end
  endtask

  // Entered at the negedge of the first HOLD cycle; leaves at the first IDLE cycle.
  task automatic hold_accept(input int hw, input logic [31:0] exp_inst, input logic exp_adef);
    for (int i = 0; i <= hw; i++) begin
      chk1("hold_valid", out_valid, 1'b1);
      chk32("hold_pc", out_pc, ref_pc);
      chk32("hold_inst", out_inst, exp_inst);
      chk1("hold_adef", out_adef, exp_adef);
      chk1("hold_req", inst_sram_req, 1'b0);
      chk1("hold_allowin", in_allowin, 1'b0);
      noise(1'b1, 1'b1);
      out_allowin = (i == hw);
      tick();
    end
    out_allowin       = 1'b0;
    in_valid          = 1'b0;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    chk1("idle_allowin", in_allowin, 1'b1);
    chk1("idle_valid", out_valid, 1'b0);
    chk1("idle_adef", out_adef, 1'b0);
    chk1("idle_req", inst_sram_req, 1'b0);
  endtask

  // Entered in IDLE: optional idle cycles, then one token, then the full fetch or exception.
  task automatic transact(input bit taken, input logic [31:0] target, input int idle,
                          input int aw, input int dw, input int hw);
    logic [31:0] data;
    for (int i = 0; i < idle; i++) begin
      chk1("idle_wait_allowin", in_allowin, 1'b1);
      chk1("idle_wait_valid", out_valid, 1'b0);
      in_valid = 1'b0;
      tick();
    end
    chk1("tok_allowin", in_allowin, 1'b1);
    in_valid     = 1'b1;
    in_br_taken  = taken;
    in_br_target = target;
    ref_pc       = taken ? target : ref_pc + 32'd4;
    tick();
    in_valid = 1'b0;
    if (ref_pc[1:0] == 2'b00) begin
      data = $urandom;
      run_fetch(aw, dw, data);
      hold_accept(hw, data, 1'b0);
    end else begin
      chk1("adef_no_req", inst_sram_req, 1'b0);
      hold_accept(hw, 32'd0, 1'b1);
    end
  endtask

  initial begin
    logic [31:0] t;
    logic [31:0] d;
    n_total           = 0;
    n_pass            = 0;
    reset             = 1'b1;
    in_valid          = 1'b0;
    in_br_taken       = 1'b0;
    in_br_target      = 32'd0;
    inst_sram_addr_ok = 1'b0;
    inst_sram_data_ok = 1'b0;
    inst_sram_rdata   = 32'd0;
    out_allowin       = 1'b0;
    ref_pc            = RESET_PC;

    // Reset boot
    repeat (2) tick();
    check_reset_outputs("in_reset");
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    check_reset_outputs("rst_state");
    tick();
    chk32("boot_addr", inst_sram_addr, 32'h1c00_0000);
    run_fetch(0, 0, 32'h0280_0000);
    chk32("boot_inst", out_inst, 32'h0280_0000);
    hold_accept(0, 32'h0280_0000, 1'b0);

    // Sequential fetch, zero-wait: out_valid exactly 3 cycles after the token
    chk1("seq_allowin", in_allowin, 1'b1);
    in_valid = 1'b1;
    in_br_taken = 1'b0;
    ref_pc = ref_pc + 32'd4;
    tick();
    in_valid = 1'b0;
    chk32("seq_addr", inst_sram_addr, 32'h1c00_0004);
    d = $urandom;
    run_fetch(0, 0, d);
    hold_accept(1, d, 1'b0);

    // Taken branch
    transact(1'b1, 32'h1c00_0100, 0, 0, 0, 0);
    chk32("br_pc", out_pc, 32'h1c00_0100);

    // Misaligned target
    transact(1'b1, 32'h1c00_0102, 0, 0, 0, 0);
    chk32("adef_pc", out_pc, 32'h1c00_0102);

    // Backpressure: addr_ok 4, data_ok 3, out_allowin 5 cycles late
    ref_pc = 32'h1c00_0100;
    transact(1'b1, 32'h1c00_0100, 1, 4, 3, 5);

    // Reset mid-WAIT, late data_ok after release is ignored
    in_valid = 1'b1;
    in_br_taken = 1'b0;
    ref_pc = ref_pc + 32'd4;
    tick();
    in_valid = 1'b0;
    chk1("mid_req", inst_sram_req, 1'b1);
    inst_sram_addr_ok = 1'b1;
    tick();
    inst_sram_addr_ok = 1'b0;
    chk1("mid_wait_req", inst_sram_req, 1'b0);
    reset = 1'b1;
    #1 check_reset_outputs("mid_reset");
    @(posedge clk);
    #1 reset = 1'b0;
    tick();
    check_reset_outputs("mid_rst_state");
    inst_sram_data_ok = 1'b1;
    inst_sram_rdata   = 32'hdead_beef;
    tick();
    inst_sram_data_ok = 1'b0;
    ref_pc = RESET_PC;
    chk1("refetch_no_valid", out_valid, 1'b0);
    d = $urandom;
    run_fetch(1, 1, d);
    hold_accept(0, d, 1'b0);

    // Randomized transactions
    for (int k = 0; k < 40; k++) begin
      t = $urandom;
      if ($urandom_range(3) != 0) t[1:0] = 2'b00;
      transact(1'($urandom_range(1)), t, $urandom_range(2), $urandom_range(3),
               $urandom_range(3), $urandom_range(3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the multicycle CPU, sitting directly downstream of the WB-to-IF valid register. Each accepted WB token, together with the branch result carried alongside it, advances the PC and triggers exactly one instruction fetch over the instruction SRAM request/response interface. The fetched instruction and its PC are held until the next stage (ID) accepts them. Only one instruction is ever in flight.

## Interface
- RESET_PC, 32'h1c00_0000: address of the first fetch after reset.
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  token from the WB-to-IF register (its out_valid).
- in_allowin  output  1  to the WB-to-IF register's out_allowin.
- in_br_taken  input  1  branch/jump of the retired instruction is taken; qualified by in_valid.
- in_br_target  input  32  branch target; qualified by in_valid and in_br_taken.
- inst_sram_req  output  1  fetch request.
- inst_sram_addr  output  32  fetch byte address.
- inst_sram_addr_ok  input  1  request accepted this cycle.
- inst_sram_data_ok  input  1  read data valid this cycle.
- inst_sram_rdata  input  32  instruction word.
- out_valid  output  1  fetched instruction available to ID.
- out_allowin  input  1  ID accepts this cycle.
- out_pc  output  32  PC of the held instruction.
- out_inst  output  32  held instruction word; 0 when out_adef=1.
- out_adef  output  1  fetch-address misalignment exception flag.

## Operation
- State register, asynchronously reset to RST. States: RST, IDLE, REQ, WAIT, HOLD.
- RST: one cycle after reset deassertion; then go to REQ with pc=RESET_PC. The first fetch needs no token.
- IDLE: in_allowin=1.
  - If in_valid, load pc <= in_br_taken ? in_br_target : pc+4, with 32-bit wrap.
  - Then go to REQ if next_pc[1:0]==0. Otherwise go to HOLD with out_adef=1 and out_inst=0, issuing no SRAM request.
- REQ: inst_sram_req=1 and inst_sram_addr=pc. On inst_sram_addr_ok, go to WAIT.
- WAIT: on inst_sram_data_ok, capture inst_sram_rdata into the instruction buffer and go to HOLD.
- HOLD: out_valid=1. On out_allowin, go to IDLE and clear out_adef.
- in_allowin=1 only in IDLE. in_valid outside IDLE is ignored; upstream holds it.
- inst_sram_addr_ok outside REQ and inst_sram_data_ok outside WAIT are ignored.
- Responses never arrive in the same cycle as their own addr_ok. data_ok is sampled from the cycle after addr_ok onward.
- inst_sram_req is registered-state decoded; it must not depend combinationally on inst_sram_addr_ok.
- out_pc always equals pc. out_inst is valid only while out_valid=1.

## Timing
- While reset is asserted, and in RST:
  - inst_sram_req=0, in_allowin=0, out_valid=0, out_adef=0.
  - pc, out_pc and inst_sram_addr = RESET_PC.
  - out_inst=0.
- Reset asserted in any state (including mid-WAIT) returns to RST immediately. After reset, a late data_ok for the aborted fetch is ignored, because it arrives outside WAIT or before the new request is accepted.
- Token accepted at edge t (IDLE & in_valid): inst_sram_req=1 in cycle t+1.
- Minimum latency, token to out_valid: 3 cycles, with addr_ok in t+1 and data_ok in t+2.
- Misaligned path: out_valid is asserted in cycle t+1.
- out_valid, out_pc, out_inst and out_adef stay stable while in HOLD with out_allowin=0.
- HOLD with out_allowin=1 at edge e: in_allowin=1 in cycle e+1. There is no same-cycle HOLD-to-IDLE bypass.

## Test plan
- Reset boot: release reset -> one RST cycle, then inst_sram_req=1 with addr 0x1c000000; addr_ok, then data_ok with 0x02800000 -> out_valid=1, out_pc=0x1c000000, out_inst=0x02800000.
- Sequential fetch: from IDLE at pc=0x1c000000, in_valid=1 with in_br_taken=0 -> request addr 0x1c000004; with zero-wait SRAM, out_valid rises exactly 3 cycles after the token.
- Taken branch: in_valid=1, in_br_taken=1, in_br_target=0x1c000100 -> request addr 0x1c000100; out_pc=0x1c000100.
- Misaligned target 0x1c000102 -> no inst_sram_req; next cycle out_valid=1, out_adef=1, out_inst=0; out_allowin=1 -> IDLE, out_adef=0.
- Backpressure: hold addr_ok low for 4 cycles, data_ok for 3, and out_allowin for 5 -> req stays high and addr stays stable; no spurious out_valid; outputs remain stable in HOLD; in_allowin=0 throughout.
- Reset mid-WAIT: assert reset while in WAIT, then give data_ok one cycle after release -> data ignored; refetch at 0x1c000000 proceeds normally.
